// File: rtl/mux_scan_ctrl.sv
// Scan controller for an 8:1 bit mux: steps sel over channels 0..7, dwells DWELL cycles
// on each, assembles the sampled bits into a byte and offers it on a valid/ready port.
module mux_scan_ctrl #(
    parameter int DWELL = 2,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       mux_out,
    output logic [2:0] sel,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [6:0]      cap_buf;

    assign state_dbg = state;

    // Handshake: data is offered while valid is high and is taken at the first rising
    // edge with valid && ready; valid and data are held stable until that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= 3'd0;
            data    <= 8'h00;
            valid   <= 1'b0;
            busy    <= 1'b0;
            cnt     <= '0;
            cap_buf <= 7'd0;
        end else if (abort) begin
            state <= IDLE;
            sel   <= 3'd0;
            valid <= 1'b0;
            busy  <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sel   <= 3'd0;
                    valid <= 1'b0;
                    if (start) begin
                        state   <= SCAN;
                        busy    <= 1'b1;
                        cnt     <= RELOAD;
                        cap_buf <= 7'd0;
                    end
                end
                SCAN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (sel == 3'd7) begin
                        // last channel goes straight into the output word
                        data  <= {mux_out, cap_buf};
                        valid <= 1'b1;
                        state <= HOLD;
                    end else begin
                        cap_buf[sel] <= mux_out;
                        sel          <= sel + 3'd1;
                        cnt          <= RELOAD;
                    end
                end
                HOLD: begin
                    if (ready) begin
                        valid <= 1'b0;
                        sel   <= 3'd0;
                        if (start) begin
                            state   <= SCAN;
                            cnt     <= RELOAD;
                            cap_buf <= 7'd0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    sel   <= 3'd0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a behavioural 8:1 mux; expected words are
// queued when a scan is started and checked when the controller presents them.
module tb_mux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       abort = 1'b0;
    int         cyc = 0;

    // DWELL = 2 instance
    logic       start = 1'b0, ready = 1'b0, mux_out;
    logic [7:0] in_word = 8'h00;
    logic [2:0] sel;
    logic [7:0] data;
    logic       valid, busy;
    logic [1:0] state_dbg;

    // DWELL = 1 instance
    logic       start1 = 1'b0, ready1 = 1'b0, mux_out1;
    logic [7:0] in_word1 = 8'h00;
    logic [2:0] sel1;
    logic [7:0] data1;
    logic       valid1, busy1;
    logic [1:0] state_dbg1;

    logic [7:0] exp_q[$];
    logic [7:0] exp1_q[$];
    logic [7:0] last_word;
    int         n_cmp = 0;
    int         n_err = 0;
    int         t0, t1, t2;

    assign mux_out  = in_word[sel];
    assign mux_out1 = in_word1[sel1];

    mux_scan_ctrl #(.DWELL(2), .CW(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mux_out(mux_out),
        .sel(sel), .data(data), .valid(valid), .ready(ready), .busy(busy),
        .state_dbg(state_dbg)
    );

    mux_scan_ctrl #(.DWELL(1), .CW(8)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort), .mux_out(mux_out1),
        .sel(sel1), .data(data1), .valid(valid1), .ready(ready1), .busy(busy1),
        .state_dbg(state_dbg1)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int max);
        int i;
        i = 0;
        while (valid !== 1'b1 && i < max) begin
            tick();
            i++;
        end
        check("valid_wait", {31'd0, valid}, 32'd1);
    endtask

    task automatic compare_word(input string tag);
        logic [7:0] e;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = 8'hxx;
        last_word = e;
        check(tag, {24'd0, data}, {24'd0, e});
    endtask

    task automatic accept_word();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("accept_valid", {31'd0, valid}, 32'd0);
        check("accept_sel", {29'd0, sel}, 32'd0);
        check("accept_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        // reset
        repeat (3) tick();
        check("rst_sel", {29'd0, sel}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        rst = 1'b0;
        tick();

        // basic scan, DWELL = 2
        in_word = 8'hA6;
        exp_q.push_back(8'hA6);
        do_start();
        check("basic_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("basic_sel_%0d", k), {29'd0, sel}, k / 2);
            check($sformatf("basic_nvalid_%0d", k), {31'd0, valid}, 32'd0);
            tick();
        end
        check("basic_valid", {31'd0, valid}, 32'd1);
        compare_word("basic_data");

        // backpressure: hold five cycles, then accept
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_valid", {31'd0, valid}, 32'd1);
            check("bp_data", {24'd0, data}, 32'hA6);
            check("bp_sel", {29'd0, sel}, 32'd7);
            check("bp_state", {30'd0, state_dbg}, 32'd2);
        end
        accept_word();
        check("bp_idle", {30'd0, state_dbg}, 32'd0);

        // back-to-back with input change after channel 5 of the first scan
        exp_q.push_back((8'h3C & 8'hC0) | (8'hA6 & 8'h3F));
        exp_q.push_back(8'h3C);
        start = 1'b1;
        ready = 1'b1;
        tick();
        repeat (12) tick();
        in_word = 8'h3C;
        wait_valid(40);
        compare_word("b2b_word1");
        t1 = cyc;
        tick();
        check("b2b_gap_valid", {31'd0, valid}, 32'd0);
        check("b2b_gap_busy", {31'd0, busy}, 32'd1);
        wait_valid(40);
        compare_word("b2b_word2");
        t2 = cyc;
        check("b2b_spacing", t2 - t1, 32'd17);
        start = 1'b0;
        tick();
        ready = 1'b0;
        check("b2b_end_valid", {31'd0, valid}, 32'd0);
        check("b2b_end_busy", {31'd0, busy}, 32'd0);

        // abort while sel = 3
        in_word = 8'h5A;
        do_start();
        repeat (6) tick();
        check("abort_pre_sel", {29'd0, sel}, 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sel", {29'd0, sel}, 32'd0);
        check("abort_valid", {31'd0, valid}, 32'd0);
        check("abort_data", {24'd0, data}, {24'd0, last_word});
        exp_q.push_back(8'h5A);
        do_start();
        wait_valid(40);
        compare_word("abort_rescan");
        accept_word();

        // reset mid-scan
        in_word = 8'hC3;
        do_start();
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        check("rst_scan_sel", {29'd0, sel}, 32'd0);
        check("rst_scan_data", {24'd0, data}, 32'd0);
        check("rst_scan_busy", {31'd0, busy}, 32'd0);
        check("rst_scan_valid", {31'd0, valid}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // reset during HOLD
        exp_q.push_back(8'hC3);
        do_start();
        wait_valid(40);
        compare_word("hold_word");
        tick();
        #2 rst = 1'b1;
        #1;
        check("rst_hold_sel", {29'd0, sel}, 32'd0);
        check("rst_hold_data", {24'd0, data}, 32'd0);
        check("rst_hold_valid", {31'd0, valid}, 32'd0);
        check("rst_hold_busy", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // scan after reset, with latency check
        in_word = 8'h99;
        exp_q.push_back(8'h99);
        do_start();
        t0 = cyc;
        check("post_rst_busy", {31'd0, busy}, 32'd1);
        wait_valid(40);
        check("post_rst_latency", cyc - t0, 32'd16);
        compare_word("post_rst_word");
        accept_word();

        // DWELL = 1
        in_word1 = 8'h81;
        exp1_q.push_back(8'h81);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("d1_busy", {31'd0, busy1}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("d1_sel_%0d", k), {29'd0, sel1}, k);
            check($sformatf("d1_nvalid_%0d", k), {31'd0, valid1}, 32'd0);
            tick();
        end
        check("d1_valid", {31'd0, valid1}, 32'd1);
        if (exp1_q.size() > 0) check("d1_data", {24'd0, data1}, {24'd0, exp1_q.pop_front()});
        else check("d1_data_missing", 32'd0, 32'd1);
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
        check("d1_accept_valid", {31'd0, valid1}, 32'd0);
        check("d1_accept_busy", {31'd0, busy1}, 32'd0);

        check("queue_empty", exp_q.size() + exp1_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
